// File: rtl/m_mem_arbiter.sv
// Arbitrates one single-port memory between a read-only fetch port (I) and a load/store port (D).
// Latency: request-to-ack is MEM_LAT+1 cycles; one access per MEM_LAT+2 cycles at best.
// Backpressure: req/ack handshake; a port waits with req held until its one-cycle ack pulse.
module m_mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_i_req,
    input  logic [ADDR_W-1:0] w_i_adr,
    output logic              w_i_ack,
    output logic [DATA_W-1:0] w_i_rd,
    input  logic              w_d_req,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_adr,
    input  logic [DATA_W-1:0] w_d_wd,
    output logic              w_d_ack,
    output logic [DATA_W-1:0] w_d_rd,
    output logic              w_mem_en,
    output logic              w_mem_we,
    output logic [ADDR_W-1:0] w_mem_adr,
    output logic [DATA_W-1:0] w_mem_wd,
    input  logic [DATA_W-1:0] w_mem_rd,
    output logic              w_busy
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    // Ack is registered one cycle ahead, so it is scheduled when the counter reads MEM_LAT-1.
    localparam logic [CNT_W-1:0] CNT_ACK = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_BUSY = 2'd1,
        S_D_BUSY = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;   // 0 = I granted last, 1 = D granted last

    // Grant, memory command capture, latency count and ack generation.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            w_mem_en  <= 1'b0;
            w_mem_we  <= 1'b0;
            w_mem_adr <= '0;
            w_mem_wd  <= '0;
            w_i_ack   <= 1'b0;
            w_d_ack   <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            w_mem_en <= 1'b0;
            w_mem_we <= 1'b0;
            w_i_ack  <= 1'b0;
            w_d_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // On a tie the port that did not win last time goes first.
                    if (w_i_req && (!w_d_req || r_last)) begin
                        r_state   <= S_I_BUSY;
                        r_last    <= 1'b0;
                        w_mem_en  <= 1'b1;
                        w_mem_adr <= w_i_adr;
                    end else if (w_d_req) begin
                        r_state   <= S_D_BUSY;
                        r_last    <= 1'b1;
                        w_mem_en  <= 1'b1;
                        w_mem_we  <= w_d_we;
                        w_mem_adr <= w_d_adr;
                        w_mem_wd  <= w_d_wd;
                    end
                end
                S_I_BUSY, S_D_BUSY: begin
                    if (r_cnt == CNT_END) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == CNT_ACK) begin
                        w_i_ack <= (r_state == S_I_BUSY);
                        w_d_ack <= (r_state == S_D_BUSY);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Read data is shared; each port qualifies it with its own ack.
    assign w_i_rd = w_mem_rd;
    assign w_d_rd = w_mem_rd;
    assign w_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_m_mem_arbiter.sv
module tb_m_mem_arbiter;

    logic        clk;
    logic        rst;
    // MEM_LAT = 1 instance
    logic        i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_adr, i_rd, d_adr, d_wd, d_rd, mem_adr, mem_wd, mem_rd;
    // MEM_LAT = 3 instance
    logic        i_req3, i_ack3, d_ack3, mem_en3, mem_we3, busy3;
    logic [31:0] i_adr3, i_rd3, d_rd3, mem_adr3, mem_wd3, mem_rd3;
    // backdoor preload shared by both memory models
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_dat;

    int npass  = 0;
    int ntotal = 0;

    m_mem_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) dut (
        .w_clk(clk), .w_rst(rst),
        .w_i_req(i_req), .w_i_adr(i_adr), .w_i_ack(i_ack), .w_i_rd(i_rd),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_adr(d_adr), .w_d_wd(d_wd),
        .w_d_ack(d_ack), .w_d_rd(d_rd),
        .w_mem_en(mem_en), .w_mem_we(mem_we), .w_mem_adr(mem_adr), .w_mem_wd(mem_wd),
        .w_mem_rd(mem_rd), .w_busy(busy)
    );

    m_mem_arbiter #(.MEM_LAT(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .w_clk(clk), .w_rst(rst),
        .w_i_req(i_req3), .w_i_adr(i_adr3), .w_i_ack(i_ack3), .w_i_rd(i_rd3),
        .w_d_req(1'b0), .w_d_we(1'b0), .w_d_adr(32'h0), .w_d_wd(32'h0),
        .w_d_ack(d_ack3), .w_d_rd(d_rd3),
        .w_mem_en(mem_en3), .w_mem_we(mem_we3), .w_mem_adr(mem_adr3), .w_mem_wd(mem_wd3),
        .w_mem_rd(mem_rd3), .w_busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with one cycle read latency.
    logic [31:0] mem1 [0:63];
    always @(posedge clk) begin
        if (bd_we) mem1[bd_idx] <= bd_dat;
        else if (mem_en && mem_we) mem1[mem_adr[7:2]] <= mem_wd;
        if (mem_en) mem_rd <= mem1[mem_adr[7:2]];
    end

    // Memory with three cycle read latency (read-only use).
    logic [31:0] mem3 [0:63];
    logic [31:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        if (bd_we) mem3[bd_idx] <= bd_dat;
        p3_0 <= mem3[mem_adr3[7:2]];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rd3 = p3_2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int          ack_cyc;
        int          en_cnt;
        logic [31:0] ack_dat;
        logic        exp_d;

        rst = 1'b1;
        i_req = 0; i_adr = 0; d_req = 0; d_we = 0; d_adr = 0; d_wd = 0;
        i_req3 = 0; i_adr3 = 0;
        bd_we = 0; bd_idx = 0; bd_dat = 0;

        // Preload while in reset.
        tick();
        bd_we = 1; bd_idx = 6'd0; bd_dat = 32'h0070_0093; tick();
        bd_idx = 6'd1; bd_dat = 32'h1111_1111; tick();
        bd_idx = 6'd3; bd_dat = 32'h3333_3333; tick();
        bd_we = 0;

        // Reset held 2 cycles with both requests high.
        i_req = 1; d_req = 1; d_adr = 32'h20;
        tick(); tick();
        check("rst_mem_en",  {31'b0, mem_en},  32'd0);
        check("rst_mem_we",  {31'b0, mem_we},  32'd0);
        check("rst_mem_adr", mem_adr,          32'd0);
        check("rst_mem_wd",  mem_wd,           32'd0);
        check("rst_i_ack",   {31'b0, i_ack},   32'd0);
        check("rst_d_ack",   {31'b0, d_ack},   32'd0);
        check("rst_busy",    {31'b0, busy},    32'd0);
        check("rst_busy3",   {31'b0, busy3},   32'd0);

        // Lone fetch from address 0.
        rst = 0; i_req = 1; i_adr = 0; d_req = 0; d_adr = 0;
        check("fetch_c0_busy", {31'b0, busy}, 32'd0);
        tick();
        check("fetch_c1_en",   {31'b0, mem_en}, 32'd1);
        check("fetch_c1_we",   {31'b0, mem_we}, 32'd0);
        check("fetch_c1_adr",  mem_adr,         32'd0);
        check("fetch_c1_busy", {31'b0, busy},   32'd1);
        check("fetch_c1_ack",  {31'b0, i_ack},  32'd0);
        tick();
        check("fetch_c2_ack",  {31'b0, i_ack},  32'd1);
        check("fetch_c2_rd",   i_rd,            32'h0070_0093);
        check("fetch_c2_en",   {31'b0, mem_en}, 32'd0);
        check("fetch_c2_busy", {31'b0, busy},   32'd1);
        check("fetch_c2_dack", {31'b0, d_ack},  32'd0);
        i_req = 0;
        tick();
        check("fetch_c3_busy", {31'b0, busy},   32'd0);
        check("fetch_c3_ack",  {31'b0, i_ack},  32'd0);

        // Store 7 to address 8.
        d_req = 1; d_we = 1; d_adr = 32'd8; d_wd = 32'd7;
        tick();
        check("st_c1_en",  {31'b0, mem_en}, 32'd1);
        check("st_c1_we",  {31'b0, mem_we}, 32'd1);
        check("st_c1_adr", mem_adr,         32'd8);
        check("st_c1_wd",  mem_wd,          32'd7);
        d_wd = 32'hdead;   // change after grant must be ignored
        tick();
        check("st_c2_ack", {31'b0, d_ack},  32'd1);
        check("st_c2_we",  {31'b0, mem_we}, 32'd0);
        check("st_c2_iack",{31'b0, i_ack},  32'd0);
        d_req = 0;
        tick();
        check("st_c3_busy", {31'b0, busy},  32'd0);

        // Load back from address 8.
        d_req = 1; d_we = 0; d_adr = 32'd8;
        tick();
        check("ld_c1_en", {31'b0, mem_en}, 32'd1);
        check("ld_c1_we", {31'b0, mem_we}, 32'd0);
        tick();
        check("ld_c2_ack", {31'b0, d_ack}, 32'd1);
        check("ld_c2_rd",  d_rd,           32'd7);
        d_req = 0;
        tick();
        check("ld_c3_busy", {31'b0, busy}, 32'd0);

        // Tie from reset: grants alternate I, D, I, D.
        rst = 1;
        tick();
        rst = 0; i_req = 1; i_adr = 32'd4; d_req = 1; d_we = 0; d_adr = 32'd12;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 1);
            tick();
            check($sformatf("tie%0d_en", k),  {31'b0, mem_en}, 32'd1);
            check($sformatf("tie%0d_adr", k), mem_adr, exp_d ? 32'd12 : 32'd4);
            check($sformatf("tie%0d_we", k),  {31'b0, mem_we}, 32'd0);
            tick();
            check($sformatf("tie%0d_iack", k), {31'b0, i_ack}, {31'b0, ~exp_d});
            check($sformatf("tie%0d_dack", k), {31'b0, d_ack}, {31'b0, exp_d});
            check($sformatf("tie%0d_rd", k), exp_d ? d_rd : i_rd,
                  exp_d ? 32'h3333_3333 : 32'h1111_1111);
            tick();
            check($sformatf("tie%0d_idle", k), {31'b0, busy}, 32'd0);
        end
        i_req = 0; d_req = 0;
        tick();

        // MEM_LAT = 3 fetch: ack 4 cycles after the request cycle.
        i_req3 = 1; i_adr3 = 0;
        ack_cyc = -1; en_cnt = 0; ack_dat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_en3) en_cnt++;
            if (i_ack3 && ack_cyc < 0) begin
                ack_cyc = c;
                ack_dat = i_rd3;
                i_req3 = 0;
            end
        end
        check("lat3_ack_cycle", ack_cyc, 32'd4);
        check("lat3_en_count",  en_cnt,  32'd1);
        check("lat3_rd",        ack_dat, 32'h0070_0093);
        check("lat3_idle",      {31'b0, busy3}, 32'd0);

        // Reset during cycle 1 of a store drops it without an ack.
        d_req = 1; d_we = 1; d_adr = 32'd16; d_wd = 32'h55;
        tick();
        check("rs_c1_en", {31'b0, mem_en}, 32'd1);
        rst = 1; d_req = 0;
        tick();
        check("rs_busy", {31'b0, busy},   32'd0);
        check("rs_dack", {31'b0, d_ack},  32'd0);
        check("rs_en",   {31'b0, mem_en}, 32'd0);
        rst = 0;
        tick();
        check("rs_dack2", {31'b0, d_ack}, 32'd0);
        check("rs_busy2", {31'b0, busy},  32'd0);
        i_req = 1; i_adr = 0;
        tick();
        check("rs_i_en", {31'b0, mem_en}, 32'd1);
        check("rs_i_we", {31'b0, mem_we}, 32'd0);
        tick();
        check("rs_i_ack",  {31'b0, i_ack}, 32'd1);
        check("rs_i_rd",   i_rd,           32'h0070_0093);
        check("rs_i_dack", {31'b0, d_ack}, 32'd0);
        i_req = 0;
        tick();
        check("rs_i_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
